sig_compactor: RTL

- Response-side signature compactor: the receiving end of the LFSR-stimulus / serial-response test structure.
- Accepts a serial response bit stream over a valid/ready handshake and folds each accepted bit into a 64-bit MISR (feedback taps 63, 2, 0).
- After a programmed number of bits, compares the MISR against an expected signature and reports pass/fail.
- Sits beside the device under test in self-checking regression benches; replaces hand-coded sum accumulation and final compare.

---
 rtl/sig_compactor_pkg.sv | 39 +++
 rtl/sig_misr.sv | 47 ++++
 rtl/sig_compactor.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sig_compactor_pkg.sv
// sig_compactor_pkg: shared types, constants and the MISR step function for
// the response-side signature compactor.
//   state_e    : compactor FSM states (3-bit encoding)
//   misr_next  : one MISR step for a signature of runtime-selected width
//                (taps at width-1, TAP_MID, TAP_LSB), evaluated on a vector
//                of SIG_W_MAX bits so one function serves any SIG_W.
package sig_compactor_pkg;

  localparam int unsigned SIG_W_DEFAULT = 64;
  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned SIG_W_MAX     = 256;
  localparam int unsigned TAP_MID       = 2;
  localparam int unsigned TAP_LSB       = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CHECK,
    DONE
  } state_e;

  // Shift left, feed back taps XOR the incoming bit into bit 0, and clear
  // everything above the active width.
  function automatic logic [SIG_W_MAX-1:0] misr_next(
    input logic [SIG_W_MAX-1:0] cur,
    input logic                 in_bit,
    input int unsigned          width
  );
    logic [7:0]           top_idx;
    logic                 fb;
    logic [SIG_W_MAX-1:0] mask;
    top_idx = 8'(width - 1);
    fb      = cur[top_idx] ^ cur[TAP_MID] ^ cur[TAP_LSB];
    mask    = {SIG_W_MAX{1'b1}} >> (SIG_W_MAX - width);
    return {cur[SIG_W_MAX-2:0], fb ^ in_bit} & mask;
  endfunction

endpackage

// File: rtl/sig_misr.sv
// sig_misr: multiple-input signature register holding the compactor signature.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset (clears the signature)
//   load_i   : load seed_i (has priority over step_i)
//   seed_i   : value loaded on load_i
//   step_i   : fold in_bit_i into the signature
//   in_bit_i : serial response bit
//   sig_o    : current signature
module sig_misr
  import sig_compactor_pkg::*;
#(
  parameter int unsigned SIG_W = SIG_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [SIG_W-1:0] seed_i,
  input  logic             step_i,
  input  logic             in_bit_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0]     sig_q;
  logic [SIG_W-1:0]     sig_d;
  logic [SIG_W_MAX-1:0] nxt;

  always_comb begin
    nxt   = misr_next(SIG_W_MAX'(sig_q), in_bit_i, SIG_W);
    sig_d = sig_q;
    if (load_i) begin
      sig_d = seed_i;
    end else if (step_i) begin
      sig_d = nxt[SIG_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/sig_compactor.sv
// sig_compactor: folds a serial response stream into a MISR and compares the
// final signature against a golden value.
//   clk, reset_l          : clock (rising) and async active-low reset
//   start                 : begin a run (honoured in IDLE/DONE only)
//   seed, expect_sig,
//   num_bits              : run operands, captured on start
//   in_valid, in_bit      : response bit handshake input
//   in_ready              : high in RUN only
//   busy / done / pass    : LOAD|RUN|CHECK / DONE / last compare result
//   sig, count            : current signature and accepted-bit count
// Optional: define SIG_COMPACTOR_ABORT_EN to add input abort and output
// aborted; abort in LOAD/RUN ends the run in DONE with pass=0.
module sig_compactor
  import sig_compactor_pkg::*;
#(
  parameter int unsigned SIG_W = SIG_W_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic [SIG_W-1:0] seed,
  input  logic [SIG_W-1:0] expect_sig,
  input  logic [CNT_W-1:0] num_bits,
  input  logic             in_valid,
  input  logic             in_bit,
`ifdef SIG_COMPACTOR_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIG_W-1:0] seed_q, seed_d;
  logic [SIG_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             pass_q, pass_d;
  logic             misr_load;
  logic             misr_step;
  logic [SIG_W-1:0] misr_sig;
`ifdef SIG_COMPACTOR_ABORT_EN
  logic             aborted_q, aborted_d;
`endif

  sig_misr #(
    .SIG_W(SIG_W)
  ) u_misr (
    .clk_i    (clk),
    .rst_ni   (reset_l),
    .load_i   (misr_load),
    .seed_i   (seed_q),
    .step_i   (misr_step),
    .in_bit_i (in_bit),
    .sig_o    (misr_sig)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seed_d    = seed_q;
    exp_d     = exp_q;
    nbits_d   = nbits_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_step = 1'b0;
`ifdef SIG_COMPACTOR_ABORT_EN
    aborted_d = aborted_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          seed_d  = seed;
          exp_d   = expect_sig;
          nbits_d = num_bits;
          state_d = LOAD;
        end
      end
      LOAD: begin
        misr_load = 1'b1;
        cnt_d     = '0;
        pass_d    = 1'b0;
        state_d   = (nbits_q == '0) ? CHECK : RUN;
`ifdef SIG_COMPACTOR_ABORT_EN
        aborted_d = 1'b0;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end
`endif
      end
      RUN: begin
`ifdef SIG_COMPACTOR_ABORT_EN
        if (abort) begin
          aborted_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = DONE;
        end else
`endif
        if (in_valid) begin
          misr_step = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          // Compare against num_bits-1 so a full-range count never wraps
          // into the comparison.
          if (cnt_q == nbits_q - 1'b1) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        pass_d  = (misr_sig == exp_q);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      seed_q    <= '0;
      exp_q     <= '0;
      nbits_q   <= '0;
      pass_q    <= 1'b0;
`ifdef SIG_COMPACTOR_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seed_q    <= seed_d;
      exp_q     <= exp_d;
      nbits_q   <= nbits_d;
      pass_q    <= pass_d;
`ifdef SIG_COMPACTOR_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == LOAD) || (state_q == RUN) || (state_q == CHECK);
  assign done     = (state_q == DONE);
  assign pass     = pass_q;
  assign sig      = misr_sig;
  assign count    = cnt_q;
`ifdef SIG_COMPACTOR_ABORT_EN
  assign aborted  = aborted_q;
`endif

endmodule
